// File: rtl/sound_fx_player_if.sv
// Game-event, frame-tick and buzzer signals of the sound effect player.
// master drives events and timing; slave (the player) drives the buzzer and status.
interface sound_fx_player_if;
    logic       startOfFrame;
    logic       mute;
    logic       ev_shot;
    logic       ev_dimond;
    logic       ev_alien_died;
    logic       ev_gold;
    logic       ev_player_died;
    logic       buzzer;
    logic       busy;
    logic [2:0] effect_id;

    modport master (
        output startOfFrame, mute,
        output ev_shot, ev_dimond, ev_alien_died, ev_gold, ev_player_died,
        input  buzzer, busy, effect_id
    );

    modport slave (
        input  startOfFrame, mute,
        input  ev_shot, ev_dimond, ev_alien_died, ev_gold, ev_player_died,
        output buzzer, busy, effect_id
    );
endinterface

// File: rtl/sound_fx_player.sv
// Priority-arbitrated sound effect sequencer: plays fixed note tables as a
// square wave on the buzzer, one note per (half-period, frame-count) pair.
module sound_fx_player (
    input  logic               clk,
    input  logic               resetN,
    sound_fx_player_if.slave   sfx
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t      state, state_next;
    logic [2:0]  effect, effect_next;
    logic [1:0]  note_idx, note_idx_next;
    logic        busy_r, busy_next;
    logic [15:0] half_period;
    logic [15:0] tone_cnt;
    logic [3:0]  duration;
    logic [3:0]  frame_cnt;
    logic        phase;
    logic [2:0]  ev_prio;
    logic        preempt;
    logic        note_end;

    // {half-period in clk cycles, duration in frames} for each note of each effect
    function automatic logic [19:0] note_entry(input logic [2:0] eff, input logic [1:0] idx);
        logic [19:0] entry;
        case ({eff, idx})
            {3'd1, 2'd0}: entry = {16'd6250,  4'd2};
            {3'd2, 2'd0}: entry = {16'd12500, 4'd3};
            {3'd2, 2'd1}: entry = {16'd8333,  4'd3};
            {3'd3, 2'd0}: entry = {16'd25000, 4'd2};
            {3'd3, 2'd1}: entry = {16'd31250, 4'd2};
            {3'd4, 2'd0}: entry = {16'd12500, 4'd4};
            {3'd4, 2'd1}: entry = {16'd9375,  4'd4};
            {3'd4, 2'd2}: entry = {16'd6250,  4'd4};
            {3'd5, 2'd0}: entry = {16'd18750, 4'd8};
            {3'd5, 2'd1}: entry = {16'd25000, 4'd8};
            {3'd5, 2'd2}: entry = {16'd31250, 4'd8};
            {3'd5, 2'd3}: entry = {16'd41667, 4'd8};
            default:      entry = {16'd1,     4'd1};
        endcase
        return entry;
    endfunction

    function automatic logic [1:0] last_note(input logic [2:0] eff);
        logic [1:0] last;
        case (eff)
            3'd2:    last = 2'd1;
            3'd3:    last = 2'd1;
            3'd4:    last = 2'd2;
            3'd5:    last = 2'd3;
            default: last = 2'd0;
        endcase
        return last;
    endfunction

    // Later assignments win, so the highest-priority pulse of the cycle survives
    always_comb begin
        ev_prio = 3'd0;
        if (sfx.ev_shot)        ev_prio = 3'd1;
        if (sfx.ev_dimond)      ev_prio = 3'd2;
        if (sfx.ev_alien_died)  ev_prio = 3'd3;
        if (sfx.ev_gold)        ev_prio = 3'd4;
        if (sfx.ev_player_died) ev_prio = 3'd5;
    end

    // effect is 0 while idle, so any event counts as a preemption there
    assign preempt  = (ev_prio != 3'd0) && (ev_prio >= effect);
    assign note_end = (state == PLAY) && sfx.startOfFrame && (frame_cnt == duration - 4'd1);

    always_comb begin
        state_next    = state;
        effect_next   = effect;
        note_idx_next = note_idx;
        busy_next     = busy_r;
        if (preempt) begin
            state_next    = LOAD;
            effect_next   = ev_prio;
            note_idx_next = 2'd0;
            busy_next     = 1'b1;
        end else begin
            case (state)
                LOAD: state_next = PLAY;
                PLAY: begin
                    if (note_end) begin
                        if (note_idx == last_note(effect)) begin
                            state_next    = IDLE;
                            effect_next   = 3'd0;
                            note_idx_next = 2'd0;
                            busy_next     = 1'b0;
                        end else begin
                            state_next    = LOAD;
                            note_idx_next = note_idx + 2'd1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= IDLE;
            effect      <= 3'd0;
            note_idx    <= 2'd0;
            busy_r      <= 1'b0;
            half_period <= 16'd0;
            duration    <= 4'd0;
            tone_cnt    <= 16'd0;
            frame_cnt   <= 4'd0;
            phase       <= 1'b0;
        end else begin
            state    <= state_next;
            effect   <= effect_next;
            note_idx <= note_idx_next;
            busy_r   <= busy_next;
            case (state)
                LOAD: begin
                    {half_period, duration} <= note_entry(effect, note_idx);
                    tone_cnt  <= 16'd0;
                    frame_cnt <= 4'd0;
                    phase     <= 1'b0;
                end
                PLAY: begin
                    if (tone_cnt == half_period - 16'd1) begin
                        tone_cnt <= 16'd0;
                        phase    <= ~phase;
                    end else begin
                        tone_cnt <= tone_cnt + 16'd1;
                    end
                    if (sfx.startOfFrame) begin
                        frame_cnt <= frame_cnt + 4'd1;
                    end
                end
                default: begin
                    tone_cnt  <= 16'd0;
                    frame_cnt <= 4'd0;
                    phase     <= 1'b0;
                end
            endcase
            // Leaving PLAY silences the buzzer on the very next cycle
            if (state_next != PLAY) begin
                phase <= 1'b0;
            end
        end
    end

    assign sfx.buzzer    = phase & ~sfx.mute;
    assign sfx.busy      = busy_r;
    assign sfx.effect_id = effect;

endmodule

// File: tb/tb_sound_fx_player.sv
// Scoreboard bench for sound_fx_player: stimulus queues expected status changes
// and buzzer rising edges with their cycle numbers; a negedge monitor matches them.
`timescale 1ns/1ps
module tb_sound_fx_player;

    localparam int HALF_CLK = 20;
    localparam int KIND_STATUS = 0;
    localparam int KIND_RISE   = 1;

    typedef struct {
        int kind;
        int cyc;
        int busy;
        int id;
    } exp_t;

    logic clk = 1'b0;
    logic resetN;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    bit   done = 1'b0;
    exp_t sb[$];
    logic [3:0] prev_status = 4'd0;
    logic       prev_buzz = 1'b0;

    sound_fx_player_if sfx ();

    sound_fx_player dut (
        .clk    (clk),
        .resetN (resetN),
        .sfx    (sfx.slave)
    );

    always #HALF_CLK clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_status(input int at, input int b, input int id);
        exp_t e;
        e.kind = KIND_STATUS; e.cyc = at; e.busy = b; e.id = id;
        sb.push_back(e);
    endtask

    task automatic expect_rise(input int at);
        exp_t e;
        e.kind = KIND_RISE; e.cyc = at; e.busy = 0; e.id = 0;
        sb.push_back(e);
    endtask

    task automatic report_event(input int kind, input int b, input int id);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_event: got kind %0d busy %0d id %0d expected none (cycle %0d)",
                     kind, b, id, cyc);
        end else begin
            e = sb.pop_front();
            checkOutput("event_kind", kind, e.kind);
            checkOutput("event_cycle", cyc, e.cyc);
            if (kind == KIND_STATUS && e.kind == KIND_STATUS) begin
                checkOutput("busy", b, e.busy);
                checkOutput("effect_id", id, e.id);
            end
        end
    endtask

    // Monitor: every status change and every buzzer rising edge must match the queue head
    always @(negedge clk) begin
        if (mon_en) begin
            if ({sfx.busy, sfx.effect_id} != prev_status) begin
                report_event(KIND_STATUS, int'(sfx.busy), int'(sfx.effect_id));
            end
            if (sfx.buzzer && !prev_buzz) begin
                report_event(KIND_RISE, 0, 0);
            end
        end
        prev_status <= {sfx.busy, sfx.effect_id};
        prev_buzz   <= sfx.buzzer;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // ev bits: [0] shot, [1] dimond, [2] alien, [3] gold, [4] death; called at a negedge
    task automatic applyStimulus(input logic [4:0] ev, input logic sof, output int at);
        at = cyc;
        sfx.ev_shot        = ev[0];
        sfx.ev_dimond      = ev[1];
        sfx.ev_alien_died  = ev[2];
        sfx.ev_gold        = ev[3];
        sfx.ev_player_died = ev[4];
        sfx.startOfFrame   = sof;
        @(negedge clk);
        sfx.ev_shot        = 1'b0;
        sfx.ev_dimond      = 1'b0;
        sfx.ev_alien_died  = 1'b0;
        sfx.ev_gold        = 1'b0;
        sfx.ev_player_died = 1'b0;
        sfx.startOfFrame   = 1'b0;
    endtask

    task automatic frame(input bit ends_effect, output int at);
        idle(2);
        if (ends_effect) expect_status(cyc + 1, 0, 0);
        applyStimulus(5'b00000, 1'b1, at);
    endtask

    task automatic start_effect(input logic [4:0] ev, input int id, output int at);
        expect_status(cyc + 1, 1, id);
        applyStimulus(ev, 1'b0, at);
    endtask

    initial begin
        #(2 * HALF_CLK * 95000);
        failures++;
        $display("[TB] FAIL watchdog: got cycle %0d expected completion before 95000", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int at, t0, s;
        resetN = 1'b0;
        sfx.mute = 1'b0;
        sfx.startOfFrame = 1'b0;
        sfx.ev_shot = 1'b0;
        sfx.ev_dimond = 1'b0;
        sfx.ev_alien_died = 1'b0;
        sfx.ev_gold = 1'b0;
        sfx.ev_player_died = 1'b0;
        idle(3);
        checkOutput("reset_busy", int'(sfx.busy), 0);
        checkOutput("reset_effect_id", int'(sfx.effect_id), 0);
        checkOutput("reset_buzzer", int'(sfx.buzzer), 0);
        mon_en = 1'b1;

        $display("[TB] shot accepted on first cycle out of reset");
        expect_status(cyc + 1, 1, 1);
        expect_rise(cyc + 2 + 6250);
        resetN = 1'b1;
        applyStimulus(5'b00001, 1'b0, t0);
        wait_until(t0 + 6256);
        frame(1'b0, at);
        frame(1'b1, at);
        checkOutput("shot_end_buzzer", int'(sfx.buzzer), 0);
        idle(5);

        $display("[TB] gold: three notes, four frames each");
        start_effect(5'b01000, 4, at);
        for (int i = 0; i < 8; i++) frame(1'b0, s);
        expect_rise(s + 2 + 6250);
        wait_until(s + 6256);
        for (int i = 0; i < 3; i++) frame(1'b0, at);
        checkOutput("gold_busy_after_11_frames", int'(sfx.busy), 1);
        frame(1'b1, at);
        idle(5);

        $display("[TB] dimond preempted by alien, later shot ignored");
        start_effect(5'b00010, 2, at);
        for (int i = 0; i < 3; i++) frame(1'b0, at);
        idle(3);
        expect_status(cyc + 1, 1, 3);
        expect_rise(cyc + 2 + 25000);
        applyStimulus(5'b00100, 1'b0, t0);
        idle(100);
        applyStimulus(5'b00001, 1'b0, at);
        checkOutput("alien_id_after_shot", int'(sfx.effect_id), 3);
        wait_until(t0 + 25005);
        for (int i = 0; i < 3; i++) frame(1'b0, at);
        frame(1'b1, at);
        idle(5);

        $display("[TB] dimond unmuted then muted with the same frame schedule");
        start_effect(5'b00010, 2, at);
        for (int i = 0; i < 5; i++) frame(1'b0, at);
        frame(1'b1, at);
        idle(5);
        sfx.mute = 1'b1;
        idle(2);
        start_effect(5'b00010, 2, at);
        for (int i = 0; i < 3; i++) frame(1'b0, s);
        wait_until(s + 8400);
        checkOutput("muted_buzzer", int'(sfx.buzzer), 0);
        checkOutput("muted_busy", int'(sfx.busy), 1);
        for (int i = 0; i < 2; i++) frame(1'b0, at);
        frame(1'b1, at);
        idle(3);
        sfx.mute = 1'b0;
        idle(5);

        $display("[TB] simultaneous events, death restart, reset with gold");
        start_effect(5'b11001, 5, at);
        for (int i = 0; i < 5; i++) frame(1'b0, at);
        idle(2);
        expect_rise(cyc + 2 + 18750);
        applyStimulus(5'b10000, 1'b0, t0);
        wait_until(t0 + 18755);
        for (int i = 0; i < 7; i++) frame(1'b0, at);
        checkOutput("death_note0_after_7_frames", int'(sfx.buzzer), 1);
        frame(1'b0, at);
        checkOutput("death_note0_end_buzzer", int'(sfx.buzzer), 0);
        idle(3);
        expect_status(cyc + 1, 0, 0);
        resetN = 1'b0;
        sfx.ev_gold = 1'b1;
        @(negedge clk);
        resetN = 1'b1;
        sfx.ev_gold = 1'b0;
        idle(5);
        checkOutput("post_reset_busy", int'(sfx.busy), 0);
        checkOutput("post_reset_effect_id", int'(sfx.effect_id), 0);
        checkOutput("post_reset_buzzer", int'(sfx.buzzer), 0);

        idle(10);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL missing_event: got nothing expected kind %0d at cycle %0d", e.kind, e.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        done = 1'b1;
        $finish;
    end

endmodule
